// File: rtl/d_stream_monitor.sv
// Observer for an asynchronous toggle stream: synchronizes d_in, flags edges,
// counts them, measures edge-to-edge intervals and reports lock/error status.
module d_stream_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_in,
  input  logic             clear,
  output logic             q_sync,
  output logic             rise,
  output logic             fall,
  output logic [15:0]      edge_cnt,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_ONE;
  localparam logic [MW-1:0]    M_ONE      = MW'(1);
  localparam logic [MW-1:0]    LOCK_VAL   = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t           state_r;
  logic             s1_r, s2_r, s3_r;
  logic [CNT_W-1:0] run_cnt_r;
  logic [MW-1:0]    match_r;
  logic [CNT_W-1:0] interval_s;
  logic [MW-1:0]    match_inc_s;
  logic             edge_s;
  logic             timeout_s;

  assign q_sync      = s2_r;
  assign rise        = s2_r & ~s3_r;
  assign fall        = ~s2_r & s3_r;
  assign edge_s      = rise | fall;
  assign interval_s  = (run_cnt_r == CNT_MAX) ? CNT_MAX : (run_cnt_r + CNT_ONE);
  assign match_inc_s = match_r + M_ONE;
  // The run counter hits saturation on this very cycle, with no edge arriving.
  assign timeout_s   = ~edge_s & (run_cnt_r == CNT_MAX_M1);

  // Synchronizer chain; deliberately untouched by clear so no false edge appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= d_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Edge counting, interval measurement and the lock-tracking FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      run_cnt_r    <= '0;
      match_r      <= '0;
      edge_cnt     <= 16'h0000;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else if (clear) begin
      state_r      <= IDLE;
      run_cnt_r    <= '0;
      match_r      <= '0;
      edge_cnt     <= 16'h0000;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      err          <= 1'b0;
    end else begin
      if (edge_s) begin
        edge_cnt  <= edge_cnt + 16'h0001;
        run_cnt_r <= '0;
      end else if (run_cnt_r != CNT_MAX) begin
        run_cnt_r <= run_cnt_r + CNT_ONE;
      end else begin
        run_cnt_r <= run_cnt_r;
      end

      case (state_r)
        IDLE: begin
          if (edge_s) begin
            state_r <= MEASURE;
          end else begin
            state_r <= IDLE;
          end
        end
        MEASURE: begin
          if (edge_s) begin
            period       <= interval_s;
            period_valid <= 1'b1;
            match_r      <= M_ONE;
            state_r      <= TRACK;
          end else begin
            state_r <= MEASURE;
          end
        end
        TRACK: begin
          if (edge_s) begin
            if (interval_s == period) begin
              match_r <= match_inc_s;
              if (match_inc_s == LOCK_VAL) begin
                state_r <= LOCKED;
                locked  <= 1'b1;
              end else begin
                state_r <= TRACK;
              end
            end else begin
              period  <= interval_s;
              match_r <= M_ONE;
              state_r <= TRACK;
            end
          end else if (timeout_s) begin
            err          <= 1'b1;
            locked       <= 1'b0;
            period_valid <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= TRACK;
          end
        end
        LOCKED: begin
          if (edge_s) begin
            if (interval_s != period) begin
              err     <= 1'b1;
              locked  <= 1'b0;
              period  <= interval_s;
              match_r <= M_ONE;
              state_r <= TRACK;
            end else begin
              state_r <= LOCKED;
            end
          end else if (timeout_s) begin
            err          <= 1'b1;
            locked       <= 1'b0;
            period_valid <= 1'b0;
            state_r      <= IDLE;
          end else begin
            state_r <= LOCKED;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_stream_monitor.sv
// Directed plus randomized bench for d_stream_monitor, compared every cycle
// against an event-level model built on edge timestamps.
module tb_d_stream_monitor;

  localparam int CW   = 4;
  localparam int LC   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_in = 1'b0;
  logic          clear = 1'b0;
  logic          q_sync, rise, fall, period_valid, locked, err;
  logic [15:0]   edge_cnt;
  logic [CW-1:0] period;

  int checks = 0;
  int errors = 0;

  // Model state: history of sampled d_in, edge timestamps and tracking status.
  bit          dq[$];
  int          cyc = 0;
  int          m_mark = 0;
  logic [15:0] m_edges = 16'h0000;
  int          m_period = 0;
  bit          m_pvalid = 1'b0;
  bit          m_locked = 1'b0;
  bit          m_err = 1'b0;
  bit          m_have_ref = 1'b0;
  int          m_matches = 0;
  bit          cur_d = 1'b0;

  d_stream_monitor #(.CNT_W(CW), .LOCK_COUNT(LC)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .clear(clear),
    .q_sync(q_sync), .rise(rise), .fall(fall), .edge_cnt(edge_cnt),
    .period(period), .period_valid(period_valid), .locked(locked), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_edges = 16'h0000; m_period = 0; m_pvalid = 1'b0; m_locked = 1'b0;
    m_err = 1'b0; m_have_ref = 1'b0; m_matches = 0; m_mark = cyc;
  endtask

  task automatic model_edge();
    int iv;
    iv = cyc - m_mark;
    if (iv > MAXV) iv = MAXV;
    m_mark = cyc;
    m_edges = m_edges + 16'h0001;
    if (!m_have_ref) begin
      m_have_ref = 1'b1;
    end else if (!m_pvalid) begin
      m_period = iv; m_pvalid = 1'b1; m_matches = 1;
    end else if (iv == m_period) begin
      if (!m_locked) begin
        m_matches++;
        if (m_matches == LC) m_locked = 1'b1;
      end
    end else begin
      if (m_locked) m_err = 1'b1;
      m_locked = 1'b0; m_period = iv; m_matches = 1;
    end
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit d, input bit c);
    bit edge_seen;
    d_in = d; clear = c;
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin
      dq = '{1'b0, 1'b0, 1'b0, 1'b0};
      model_clear();
    end else begin
      dq.push_front(d);
      void'(dq.pop_back());
      edge_seen = (dq[2] != dq[3]);
      if (c) begin
        model_clear();
      end else if (edge_seen) begin
        model_edge();
      end else if (m_pvalid && (cyc - m_mark) == MAXV) begin
        m_err = 1'b1; m_locked = 1'b0; m_pvalid = 1'b0; m_have_ref = 1'b0;
      end
    end
    chk("q_sync", {31'd0, q_sync}, {31'd0, dq[1]});
    chk("rise", {31'd0, rise}, {31'd0, dq[1] & ~dq[2]});
    chk("fall", {31'd0, fall}, {31'd0, ~dq[1] & dq[2]});
    chk("edge_cnt", {16'd0, edge_cnt}, {16'd0, m_edges});
    chk("period", {28'd0, period}, m_period);
    chk("period_valid", {31'd0, period_valid}, {31'd0, m_pvalid});
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(cur_d, 1'b0);
  endtask

  task automatic toggle(input int n);
    cur_d = ~cur_d;
    step(cur_d, 1'b0);
    hold(n - 1);
  endtask

  initial begin
    dq = '{1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with d_in toggling, then released with d_in low
    for (int i = 0; i < 3; i++) step(i[0], 1'b0);
    rst_n = 1'b1;
    cur_d = 1'b0;
    hold(10);
    chk("idle_edges", {16'd0, edge_cnt}, 32'd0);

    // Steady 7-cycle toggle until locked
    for (int i = 0; i < 8; i++) toggle(7);
    chk("steady_period", {28'd0, period}, 32'd7);
    chk("steady_locked", {31'd0, locked}, 32'd1);
    chk("steady_err", {31'd0, err}, 32'd0);
    chk("steady_edges", {16'd0, edge_cnt}, 32'd8);

    // Rate change to 5 while locked
    for (int i = 0; i < 6; i++) toggle(5);
    chk("rate_period", {28'd0, period}, 32'd5);
    chk("rate_err", {31'd0, err}, 32'd1);
    chk("rate_relock", {31'd0, locked}, 32'd1);

    // Lock at 3, then hold until timeout
    for (int i = 0; i < 7; i++) toggle(3);
    chk("lock3_locked", {31'd0, locked}, 32'd1);
    hold(20);
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_locked", {31'd0, locked}, 32'd0);
    chk("timeout_pvalid", {31'd0, period_valid}, 32'd0);
    toggle(4);
    chk("post_timeout_period", {28'd0, period}, 32'd3);
    chk("post_timeout_pvalid", {31'd0, period_valid}, 32'd0);

    // Clear in the same cycle the rise pulse is presented to the counters
    cur_d = ~cur_d;
    step(cur_d, 1'b0);
    step(cur_d, 1'b0);
    chk("collision_rise", {31'd0, rise | fall}, 32'd1);
    step(cur_d, 1'b1);
    chk("clear_edges", {16'd0, edge_cnt}, 32'd0);
    chk("clear_err", {31'd0, err}, 32'd0);
    chk("clear_pvalid", {31'd0, period_valid}, 32'd0);
    hold(4);
    toggle(4);
    toggle(4);
    chk("after_clear_edges", {16'd0, edge_cnt}, 32'd2);
    chk("after_clear_period", {28'd0, period}, 32'd4);

    // Randomized toggling with occasional clear and one reset pulse
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) == 0) cur_d = ~cur_d;
      if (i == 300) rst_n = 1'b0;
      if (i == 302) rst_n = 1'b1;
      step(cur_d, ($urandom_range(49, 0) == 0));
    end
    hold(4);

    // Edge counter wrap
    step(cur_d, 1'b1);
    for (int i = 0; i < 65535; i++) toggle(1);
    hold(2);
    chk("wrap_ffff", {16'd0, edge_cnt}, 32'h0000FFFF);
    toggle(1);
    hold(2);
    chk("wrap_zero", {16'd0, edge_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
